// File: rtl/i2c_condition_generator_if.sv
// Command handshake and bus-level signals of i2c_condition_generator.
// slave: the condition generator itself; master: the byte FSM / pad side that drives it.
interface i2c_condition_generator_if;
    logic       i_tick;
    logic       i_cmd_valid;
    logic [1:0] i_cmd;
    logic       o_cmd_ready;
    logic       i_scl;
    logic       i_sda;
    logic       o_scl;
    logic       o_sda;
    logic       o_done;
    logic       o_arb_lost;
    logic       o_timeout;

    modport slave (
        input  i_tick, i_cmd_valid, i_cmd, i_scl, i_sda,
        output o_cmd_ready, o_scl, o_sda, o_done, o_arb_lost, o_timeout
    );

    modport master (
        output i_tick, i_cmd_valid, i_cmd, i_scl, i_sda,
        input  o_cmd_ready, o_scl, o_sda, o_done, o_arb_lost, o_timeout
    );
endinterface

// File: rtl/i2c_condition_generator.sv
// I2C START / repeated START / STOP generator with tick-timed phases and SCL stretch support.
// Optional macro I2C_COND_TIMEOUT_EN adds an abort when SCL is held low too long in P1.
module i2c_condition_generator #(
    parameter int unsigned PHASE_TICKS     = 2,
    parameter int unsigned STRETCH_TIMEOUT = 1024,
    parameter int unsigned TCNT_W          = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    i2c_condition_generator_if.slave    io_bus
);

    typedef enum logic [2:0] {StIdle, StP0, StP1, StP2, StP3} state_e;

    localparam logic [1:0] CmdStart  = 2'b00;
    localparam logic [1:0] CmdRstart = 2'b01;
    localparam logic [1:0] CmdStop   = 2'b10;
    localparam logic [1:0] CmdRsvd   = 2'b11;

    localparam logic [TCNT_W-1:0] PhaseLast = TCNT_W'(PHASE_TICKS - 1);

    if (PHASE_TICKS == 0 || TCNT_W == 0 || STRETCH_TIMEOUT == 0 ||
        (64'(PHASE_TICKS) >> TCNT_W) != 64'd0 ||
        (64'(STRETCH_TIMEOUT) >> TCNT_W) != 64'd0) begin : g_bad_params
        $error("i2c_condition_generator: TCNT_W too narrow or zero tick count");
    end

    // Line drive per command and phase, packed as {scl, sda}.
    function automatic logic [1:0] f_drive(input logic [1:0] cmd, input state_e st);
        logic [1:0] d;
        d = 2'b11;
        case (cmd)
            CmdStart: begin
                case (st)
                    StP2:    d = 2'b10;
                    StP3:    d = 2'b00;
                    default: d = 2'b11;
                endcase
            end
            CmdRstart: begin
                case (st)
                    StP0:    d = 2'b01;
                    StP2:    d = 2'b10;
                    StP3:    d = 2'b00;
                    default: d = 2'b11;
                endcase
            end
            CmdStop: begin
                case (st)
                    StP0:    d = 2'b00;
                    StP1:    d = 2'b10;
                    default: d = 2'b11;
                endcase
            end
            default: d = 2'b11;
        endcase
        return d;
    endfunction

    function automatic state_e f_next(input state_e st);
        state_e n;
        case (st)
            StP0:    n = StP1;
            StP1:    n = StP2;
            StP2:    n = StP3;
            default: n = StIdle;
        endcase
        return n;
    endfunction

    state_e            r_state;
    logic [1:0]        r_cmd;
    logic [TCNT_W-1:0] r_cnt;
    logic              r_scl;
    logic              r_sda;
    logic              r_done;
    logic              r_arb_lost;

    logic w_count;
    logic w_busy;
    logic w_arb_phase;
    logic w_abort;
    logic w_tmo;

    // In P1 the phase clock only runs once the slave has let SCL go high.
    assign w_count     = (r_state != StP1) || io_bus.i_scl;
    assign w_busy      = (r_cmd == CmdStart) && (r_state == StP0) &&
                         !(io_bus.i_scl && io_bus.i_sda);
    assign w_arb_phase = (r_cmd != CmdStop) ? (r_state == StP1)
                                            : (r_state == StP2 || r_state == StP3);
    assign w_abort     = w_busy || (w_arb_phase && r_sda && !io_bus.i_sda);

`ifdef I2C_COND_TIMEOUT_EN
    localparam logic [TCNT_W-1:0] StretchLast = TCNT_W'(STRETCH_TIMEOUT - 1);

    logic [TCNT_W-1:0] r_scnt;
    logic              r_timeout;

    assign w_tmo = (r_state == StP1) && !io_bus.i_scl && (r_scnt == StretchLast);
    assign io_bus.o_timeout = r_timeout;
`else
    assign w_tmo = 1'b0;
    assign io_bus.o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cmd      <= CmdStart;
            r_cnt      <= '0;
            r_scl      <= 1'b1;
            r_sda      <= 1'b1;
            r_done     <= 1'b0;
            r_arb_lost <= 1'b0;
`ifdef I2C_COND_TIMEOUT_EN
            r_scnt     <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_arb_lost <= 1'b0;
`ifdef I2C_COND_TIMEOUT_EN
            r_timeout  <= 1'b0;
`endif
            if (r_state == StIdle) begin
                // Ticks in the acceptance cycle are deliberately ignored.
                if (io_bus.i_cmd_valid) begin
                    r_cnt <= '0;
`ifdef I2C_COND_TIMEOUT_EN
                    r_scnt <= '0;
`endif
                    if (io_bus.i_cmd == CmdRsvd) begin
                        r_done <= 1'b1;
                    end else begin
                        r_cmd            <= io_bus.i_cmd;
                        r_state          <= StP0;
                        {r_scl, r_sda}   <= f_drive(io_bus.i_cmd, StP0);
                    end
                end
            end else if (io_bus.i_tick) begin
                if (w_abort || w_tmo) begin
                    r_state    <= StIdle;
                    r_scl      <= 1'b1;
                    r_sda      <= 1'b1;
                    r_cnt      <= '0;
                    r_arb_lost <= w_abort;
`ifdef I2C_COND_TIMEOUT_EN
                    r_timeout  <= !w_abort;
`endif
                end else if (w_count) begin
                    if (r_cnt == PhaseLast) begin
                        r_cnt <= '0;
                        if (r_state == StP3) begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                        end else begin
                            r_state        <= f_next(r_state);
                            {r_scl, r_sda} <= f_drive(r_cmd, f_next(r_state));
                        end
                    end else begin
                        r_cnt <= r_cnt + TCNT_W'(1);
                    end
                end
`ifdef I2C_COND_TIMEOUT_EN
                else begin
                    r_scnt <= r_scnt + TCNT_W'(1);
                end
`endif
            end
        end
    end

    assign io_bus.o_cmd_ready = (r_state == StIdle);
    assign io_bus.o_scl       = r_scl;
    assign io_bus.o_sda       = r_sda;
    assign io_bus.o_done      = r_done;
    assign io_bus.o_arb_lost  = r_arb_lost;

endmodule

// File: tb/tb_i2c_condition_generator.sv
// Scoreboard bench for i2c_condition_generator: each issued command queues its expected
// completion event; a monitor pops and checks on every o_done / o_arb_lost / o_timeout pulse.
`timescale 1ns/1ps
module tb_i2c_condition_generator;

`ifdef I2C_COND_TIMEOUT_EN
    localparam int unsigned StretchTo = 8;
`else
    localparam int unsigned StretchTo = 1024;
`endif
    localparam int KDone = 0;
    localparam int KArb  = 1;
    localparam int KTmo  = 2;

    typedef struct {
        int    kind;
        int    ticks;     // -1 = not checked
        int    cycles;    // -1 = not checked
        logic  scl;
        logic  sda;
        int    sda_fall;  // -1 = not checked
        int    scl_fall;  // -1 = not checked
        bit    scl_hi;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic scl_hold;
    logic sda_force;
    int   tick_cnt = 0;
    int   cyc_cnt  = 0;
    int   t0       = 0;
    int   cyc0     = 0;
    int   seq      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    i2c_condition_generator_if bif();

    i2c_condition_generator #(
        .PHASE_TICKS    (2),
        .STRETCH_TIMEOUT(StretchTo),
        .TCNT_W         (16)
    ) u_dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bif.slave)
    );

    always #5 clk = ~clk;

    // Open-drain bus: a line is low if we pull it or the other side does.
    assign bif.i_scl = bif.o_scl & ~scl_hold;
    assign bif.i_sda = bif.o_sda & ~sda_force;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (bif.i_tick) tick_cnt <= tick_cnt + 1;
    end

    initial begin
        bif.i_tick = 1'b0;
        forever begin
            @(posedge clk); #1 bif.i_tick = 1'b1;
            @(posedge clk); #1 bif.i_tick = 1'b0;
            repeat (2) @(posedge clk);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int kind, input int ticks, input int cycles,
                                input logic scl, input logic sda, input int sda_fall,
                                input int scl_fall, input bit scl_hi, input string name);
        exp_t e;
        e.kind = kind; e.ticks = ticks; e.cycles = cycles; e.scl = scl; e.sda = sda;
        e.sda_fall = sda_fall; e.scl_fall = scl_fall; e.scl_hi = scl_hi; e.name = name;
        return e;
    endfunction

    task automatic issue(input logic [1:0] cmd, input bit align, input bit push, input exp_t e);
        int guard = 0;
        do begin
            @(posedge clk); #2;
            guard++;
        end while (!(bif.o_cmd_ready && (!align || bif.i_tick)) && guard < 1000);
        check({e.name, "_ready_wait"}, (guard < 1000) ? 32'd1 : 32'd0, 32'd1);
        if (guard >= 1000) return;
        bif.i_cmd_valid = 1'b1;
        bif.i_cmd       = cmd;
        @(posedge clk); #1;
        bif.i_cmd_valid = 1'b0;
        t0   = tick_cnt;
        cyc0 = cyc_cnt;
        seq++;
        if (push) exp_q.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        int guard = 0;
        while ((tick_cnt - t0) < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_ticks_bound", (guard < 2000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (8) @(negedge clk);
    endtask

    initial begin : monitor
        logic p_scl, p_sda, scl_at_fall;
        int   sda_fall, scl_fall, last_seq, npulse, kind_act;
        exp_t e;
        p_scl = 1'b1; p_sda = 1'b1; scl_at_fall = 1'bx;
        sda_fall = -1; scl_fall = -1; last_seq = 0;
        forever begin
            @(negedge clk);
            if (seq != last_seq) begin
                last_seq = seq; sda_fall = -1; scl_fall = -1; scl_at_fall = 1'bx;
            end
            if (rst_n === 1'b1) begin
                if (p_sda === 1'b1 && bif.o_sda === 1'b0) begin
                    sda_fall    = tick_cnt - t0;
                    scl_at_fall = bif.i_scl;
                end
                if (p_scl === 1'b1 && bif.o_scl === 1'b0) scl_fall = tick_cnt - t0;
                npulse = int'(bif.o_done) + int'(bif.o_arb_lost) + int'(bif.o_timeout);
                if (npulse > 0) begin
                    check("pulse_exclusive", npulse, 1);
                    kind_act = bif.o_timeout ? KTmo : (bif.o_arb_lost ? KArb : KDone);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pulse: got kind %0d at %0t, required none",
                                 kind_act, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_kind"}, kind_act, e.kind);
                        if (e.ticks >= 0) check({e.name, "_ticks"}, tick_cnt - t0, e.ticks);
                        if (e.cycles >= 0) check({e.name, "_cycles"}, cyc_cnt - cyc0, e.cycles);
                        check({e.name, "_scl"}, bif.o_scl, e.scl);
                        check({e.name, "_sda"}, bif.o_sda, e.sda);
                        check({e.name, "_ready"}, bif.o_cmd_ready, 1);
                        if (e.sda_fall >= 0) check({e.name, "_sda_fall"}, sda_fall, e.sda_fall);
                        if (e.scl_fall >= 0) check({e.name, "_scl_fall"}, scl_fall, e.scl_fall);
                        if (e.scl_hi) check({e.name, "_scl_hi_at_sda_fall"}, scl_at_fall, 1);
                    end
                end
            end
            p_scl = bif.o_scl;
            p_sda = bif.o_sda;
        end
    end

    initial begin
        exp_t none;
        none = mk(KDone, -1, -1, 1'b1, 1'b1, -1, -1, 1'b0, "none");
        rst_n = 1'b0; scl_hold = 1'b0; sda_force = 1'b0;
        bif.i_cmd_valid = 1'b0; bif.i_cmd = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_scl", bif.o_scl, 1);
        check("reset_sda", bif.o_sda, 1);
        check("reset_ready", bif.o_cmd_ready, 1);
        check("reset_pulses", {bif.o_done, bif.o_arb_lost, bif.o_timeout}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // START with a tick in the acceptance cycle; a stray valid mid-command must be ignored.
        issue(2'b00, 1'b1, 1'b1, mk(KDone, 8, -1, 1'b0, 1'b0, 4, 6, 1'b0, "start"));
        repeat (10) @(posedge clk);
        #1 bif.i_cmd_valid = 1'b1; bif.i_cmd = 2'b10;
        @(posedge clk);
        #1 bif.i_cmd_valid = 1'b0;
        wait_idle("start");
        repeat (50) @(negedge clk);
        check("start_hold_scl", bif.o_scl, 0);
        check("start_hold_sda", bif.o_sda, 0);

        issue(2'b11, 1'b0, 1'b1, mk(KDone, -1, 0, 1'b0, 1'b0, -1, -1, 1'b0, "rsvd_low"));
        wait_idle("rsvd_low");

        // Repeated START with the slave stretching SCL for 10 ticks in P1.
        scl_hold = 1'b1;
        issue(2'b01, 1'b0, 1'b1, mk(KDone, 18, -1, 1'b0, 1'b0, 14, 16, 1'b1, "rstart_stretch"));
        wait_ticks(12);
        scl_hold = 1'b0;
        wait_idle("rstart_stretch");

        issue(2'b10, 1'b0, 1'b1, mk(KDone, 8, -1, 1'b1, 1'b1, -1, -1, 1'b0, "stop"));
        wait_idle("stop");
        issue(2'b11, 1'b0, 1'b1, mk(KDone, -1, 0, 1'b1, 1'b1, -1, -1, 1'b0, "rsvd_high"));
        wait_idle("rsvd_high");

        sda_force = 1'b1;
        issue(2'b10, 1'b0, 1'b1, mk(KArb, 5, -1, 1'b1, 1'b1, -1, -1, 1'b0, "stop_arb"));
        wait_idle("stop_arb");
        issue(2'b00, 1'b0, 1'b1, mk(KArb, 1, -1, 1'b1, 1'b1, -1, -1, 1'b0, "start_busy"));
        wait_idle("start_busy");
        sda_force = 1'b0;

        // Reset in the middle of a repeated START.
        issue(2'b00, 1'b0, 1'b1, mk(KDone, 8, -1, 1'b0, 1'b0, 4, 6, 1'b0, "start2"));
        wait_idle("start2");
        issue(2'b01, 1'b0, 1'b1, mk(KDone, 8, -1, 1'b0, 1'b0, -1, -1, 1'b0, "rstart_rst"));
        wait_ticks(4);
        check("rst_mid_p2_sda", bif.o_sda, 0);
        rst_n = 1'b0;
        #1;
        check("rst_async_scl", bif.o_scl, 1);
        check("rst_async_sda", bif.o_sda, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_release_ready", bif.o_cmd_ready, 1);
        check("rst_release_lines", {bif.o_scl, bif.o_sda}, 2'b11);

`ifdef I2C_COND_TIMEOUT_EN
        scl_hold = 1'b1;
        issue(2'b01, 1'b0, 1'b1, mk(KTmo, 10, -1, 1'b1, 1'b1, -1, -1, 1'b0, "stretch_tmo"));
        wait_idle("stretch_tmo");
        scl_hold = 1'b0;
`else
        scl_hold = 1'b1;
        issue(2'b01, 1'b0, 1'b0, none);
        repeat (120) @(negedge clk);
        check("stretch_wait_ready", bif.o_cmd_ready, 0);
        check("stretch_wait_scl", bif.o_scl, 1);
        check("stretch_wait_tmo", bif.o_timeout, 0);
        exp_q.push_back(mk(KDone, -1, -1, 1'b0, 1'b0, -1, -1, 1'b0, "stretch_release"));
        scl_hold = 1'b0;
        wait_idle("stretch_release");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_condition_generator.md
Name: i2c_condition_generator

Overview:
Parametrised successor to the single-purpose START generator. Produces the I2C bus conditions START, repeated START and STOP from a command handshake. Phase timing is set by a parameter, SCL clock stretching is honoured, and arbitration loss or a busy bus is detected. Sits between the byte-level I2C master FSM and the open-drain pad drivers. A drive value of 1 means release the line; 0 means pull it low.

Parameters:
PHASE_TICKS, 2, i_tick pulses per timed phase (>=1)
STRETCH_TIMEOUT, 1024, i_tick pulses allowed waiting for SCL high (used only with I2C_COND_TIMEOUT_EN)
TCNT_W, 16, width of internal tick counter; must hold max(PHASE_TICKS, STRETCH_TIMEOUT)

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_tick  input  1  single-cycle timing strobe (bus quarter-period)
i_cmd_valid  input  1  command request
i_cmd  input  2  00 START, 01 RSTART, 10 STOP, 11 reserved
o_cmd_ready  output  1  high in IDLE; command accepted when valid & ready
i_scl  input  1  synchronised SCL bus level
i_sda  input  1  synchronised SDA bus level
o_scl  output  1  SCL drive (1 = release)
o_sda  output  1  SDA drive (1 = release)
o_done  output  1  one-cycle pulse, condition completed
o_arb_lost  output  1  one-cycle pulse, arbitration lost or bus busy
o_timeout  output  1  one-cycle pulse, stretch timeout

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_scl=1, o_sda=1, o_cmd_ready=1, all pulses 0, counters 0. Reset mid-operation releases both lines immediately.
- States: IDLE, P0, P1, P2, P3. A command register holds the accepted i_cmd.
- IDLE: o_scl and o_sda hold their last driven values. SCL stays low after START/RSTART. Accept on i_cmd_valid & o_cmd_ready, enter P0 next cycle. o_cmd_ready drops in the same cycle.
- Timed phase: drive values are updated on phase entry. The phase ends when the counter reaches PHASE_TICKS i_tick pulses.
- Phase drive values, listed as P0 / P1 / P2 / P3:
  - START: sda1 scl1 / sda1 scl1 / sda0 scl1 / sda0 scl0
  - RSTART: sda1 scl0 / sda1 scl1 / sda0 scl1 / sda0 scl0
  - STOP: sda0 scl0 / sda0 scl1 / sda1 scl1 / sda1 scl1
- P1 is a stretch-wait phase. The tick counter is held at 0 while i_scl=0 and starts counting only once i_scl=1 is sampled.
- End of P3: next state IDLE, o_done=1 for one cycle, o_cmd_ready=1 in the same cycle.
- Busy check (START only): if i_scl=0 or i_sda=0 on any i_tick during P0, abort.
- Arbitration: abort if o_sda=1 and i_sda=0 on an i_tick in these phases:
  - START/RSTART: P1.
  - STOP: P2 or P3.
- Abort: o_scl=1, o_sda=1, o_arb_lost pulse, next state IDLE, no o_done.
- Reserved cmd 11: accepted, lines unchanged, o_done pulse on the next cycle, no P-phases.
- i_tick arriving in the acceptance cycle is not counted.
- i_cmd_valid while not ready is ignored; no queuing.
- Total latency with no stretch: 4*PHASE_TICKS ticks from acceptance to o_done.
- o_done, o_arb_lost and o_timeout are mutually exclusive.

Optional Feature:
I2C_COND_TIMEOUT_EN
- Defined: P1 counts i_tick while i_scl=0. If the count reaches STRETCH_TIMEOUT, abort: o_scl=1, o_sda=1, o_timeout pulse, next state IDLE.
- Undefined: P1 waits indefinitely, o_timeout is tied to 0, STRETCH_TIMEOUT is unused.

Test Plan:
1. PHASE_TICKS=2, i_tick every 4 clocks, bus idle high, cmd START -> o_sda falls 4 ticks after acceptance, o_scl falls 6 ticks after, o_done 8 ticks after, then IDLE holding scl0/sda0.
2. After test 1, cmd RSTART with SCL held low by the slave for 10 ticks -> o_done 18 ticks after acceptance, SDA falls only while i_scl=1.
3. cmd STOP -> final state o_scl=1, o_sda=1, o_done after 8 ticks. A repeat with i_sda forced 0 during P2 -> o_arb_lost pulse, both lines released, no o_done.
4. i_sda=0 at START P0 -> o_arb_lost, both lines 1, o_cmd_ready back to 1. Also cmd 11 -> o_done the next cycle with lines unchanged.
5. i_rst_n asserted during RSTART P2 -> o_scl=1 and o_sda=1 asynchronously, o_cmd_ready=1 after release.
6. I2C_COND_TIMEOUT_EN defined, STRETCH_TIMEOUT=8, i_scl stuck 0 in P1 -> o_timeout on the 8th tick, both lines released. Without the macro -> the block stays in P1 and o_timeout stays 0.
